// File: rtl/stream_demux_n.sv
// stream_demux_n: 1:N valid/ready stream demultiplexer, one registered slot per output channel.
// Latency: exactly 1 cycle from input acceptance to out_valid; 1 beat/cycle/channel sustained.
// Backpressure: in_ready follows only the addressed channel's slot (out_ready feeds it
//   combinationally); out-of-range selects are always accepted, discarded and counted.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_data/in_sel     beat payload and destination channel
//   in_last            end-of-packet marker (only meaningful with DEMUX_PKT_LOCK_EN)
//   in_valid/in_ready  input handshake
//   out_data           channel k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready per-channel output handshake
//   drop_count         saturating count of beats dropped for out-of-range select
// Optional: define DEMUX_PKT_LOCK_EN to hold the destination for a whole packet (until in_last).
module stream_demux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_count
);
  localparam int NSEL = 1 << SEL_W;

  logic [SEL_W-1:0] sel;        // effective select
  logic             sel_ok;     // effective select names a real channel
  logic [NSEL-1:0]  valid_pad;  // per-channel flags padded to the full select range
  logic [NSEL-1:0]  ready_pad;
  logic             accept;
  logic             load;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lock_sel, lock_sel_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    case (state)
      IDLE: begin
        if (accept && !in_last) begin
          state_nxt    = LOCKED;
          lock_sel_nxt = in_sel;
        end
      end
      LOCKED: begin
        if (accept && in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Kept outside the FSM process so the select only depends on registered state.
  assign sel = (state == LOCKED) ? lock_sel : in_sel;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign sel         = in_sel;
`endif

  assign sel_ok    = (int'(sel) < CHANNELS);
  assign valid_pad = NSEL'(out_valid);
  assign ready_pad = NSEL'(out_ready);

  // While rst is held the block presents its post-reset face: every slot empty.
  assign in_ready = rst | !sel_ok | !valid_pad[sel] | ready_pad[sel];
  assign accept   = in_valid & in_ready;
  assign load     = accept & sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= '0;
      out_data   <= '0;
      drop_count <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        // A reload takes priority over a drain, giving back-to-back beats without a bubble.
        if (load && (sel == SEL_W'(k))) begin
          out_valid[k]                  <= 1'b1;
          out_data[k*WIDTH +: WIDTH]    <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k]                  <= 1'b0;
        end
      end
      if (accept && !sel_ok && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_last, in_valid, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid, out_ready;
  logic [7:0]  drop_count;

  logic [7:0]  c3_in_data;
  logic [1:0]  c3_in_sel;
  logic        c3_in_last, c3_in_valid, c3_in_ready;
  logic [23:0] c3_out_data;
  logic [2:0]  c3_out_valid, c3_out_ready;
  logic [7:0]  c3_drop;

  int total = 0;
  int bad   = 0;

  // 4 channels with a 3-bit select so out-of-range selects exist on the main instance.
  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_count(drop_count));

  stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(c3_in_data), .in_sel(c3_in_sel), .in_last(c3_in_last),
    .in_valid(c3_in_valid), .in_ready(c3_in_ready), .out_data(c3_out_data),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready), .drop_count(c3_drop));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[10];

  // Reference model: each channel is a queue of capacity one plus the last value it showed.
  logic [7:0] mq[4][$];
  logic [7:0] m_last[4];
  int         m_drop;
`ifdef DEMUX_PKT_LOCK_EN
  bit         m_lock;
  int         m_lsel;
`endif

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int e;
    bit exp_rdy;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b1; out_ready = '0;
    c3_in_valid = 1'b0; c3_in_sel = '0; c3_in_data = '0; c3_in_last = 1'b0; c3_out_ready = 3'b111;

    tbl[0] = '{1'b1, 3'd0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0};
    tbl[1] = '{1'b1, 3'd1, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0};
    tbl[2] = '{1'b1, 3'd2, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0};
    tbl[3] = '{1'b1, 3'd3, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0};
    tbl[4] = '{1'b0, 3'd0, 8'hEE, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0};
    tbl[5] = '{1'b1, 3'd2, 8'h11, 4'hB, 1'b1, 4'b0100, 32'hA311A1A0};
    tbl[6] = '{1'b1, 3'd2, 8'h22, 4'hB, 1'b0, 4'b0100, 32'hA311A1A0};
    tbl[7] = '{1'b1, 3'd1, 8'h33, 4'hB, 1'b1, 4'b0110, 32'hA31133A0};
    tbl[8] = '{1'b1, 3'd2, 8'h22, 4'hF, 1'b1, 4'b0100, 32'hA32233A0};
    tbl[9] = '{1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA32233A0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;

    // Routing and back-pressure vectors
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].dat;
      out_ready = tbl[i].ordy; in_last = 1'b1;
      #1 chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_dat);
      chk($sformatf("tbl%0d_drop", i), drop_count, 0);
    end

    // Full throughput on channel 0
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h50 + 8'(i); out_ready = 4'hF;
      #1 chk("thr_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("thr_valid0", out_valid[0], 1);
      chk("thr_data0", out_data[7:0], 8'h50 + 8'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("thr_drained", out_valid, 0);

    // Reset mid-stream with ch0 and ch3 stalled and one drop recorded
    @(negedge clk);
    out_ready = 4'h0; in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h77;
    @(negedge clk);
    in_sel = 3'd3; in_data = 8'h88;
    @(negedge clk);
    in_sel = 3'd5; in_data = 8'h99;
    @(negedge clk);
    in_valid = 1'b0; in_sel = 3'd0;
    #1;
    chk("mid_valid_before", out_valid, 4'b1001);
    chk("mid_drop_before", drop_count, 1);
    chk("mid_ready_full", in_ready, 0);
    rst = 1'b1;
    #1 chk("mid_ready_in_rst", in_ready, 1);
    @(posedge clk); #1;
    chk("mid_valid_after", out_valid, 0);
    chk("mid_data_after", out_data, 0);
    chk("mid_drop_after", drop_count, 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef DEMUX_PKT_LOCK_EN
    // Packet lock: three beats follow the first beat's select, next packet routes fresh
    out_ready = 4'hF;
    @(negedge clk);
    in_valid = 1'b1; in_sel = 3'd1; in_last = 1'b0; in_data = 8'hC1;
    @(posedge clk); #1;
    chk("lk_b1_valid", out_valid, 4'b0010);
    chk("lk_b1_data", out_data[15:8], 8'hC1);
    @(negedge clk);
    in_sel = 3'd2; in_last = 1'b0; in_data = 8'hC2;
    #1 chk("lk_b2_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("lk_b2_valid", out_valid, 4'b0010);
    chk("lk_b2_data", out_data[15:8], 8'hC2);
    @(negedge clk);
    in_sel = 3'd0; in_last = 1'b1; in_data = 8'hC3;
    @(posedge clk); #1;
    chk("lk_b3_valid", out_valid, 4'b0010);
    chk("lk_b3_data", out_data[15:8], 8'hC3);
    @(negedge clk);
    in_sel = 3'd2; in_last = 1'b1; in_data = 8'hC4;
    @(posedge clk); #1;
    chk("lk_next_valid", out_valid, 4'b0100);
    chk("lk_next_data", out_data[23:16], 8'hC4);
    // Out-of-range packet: every beat dropped and counted
    @(negedge clk);
    in_sel = 3'd5; in_last = 1'b0;
    @(negedge clk);
    in_sel = 3'd1; in_last = 1'b0;
    @(negedge clk);
    in_sel = 3'd0; in_last = 1'b1;
    @(posedge clk); #1;
    chk("lk_drop_valid", out_valid, 0);
    chk("lk_drop_count", drop_count, 3);
    @(negedge clk);
    in_valid = 1'b0;
`endif

    // Randomized run against the model
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      m_last[k] = 8'h00;
    end
    m_drop = 0;
`ifdef DEMUX_PKT_LOCK_EN
    m_lock = 1'b0; m_lsel = 0;
`endif
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sel    = 3'($urandom_range(0, 5));
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = 4'($urandom);
      #1;
      e = int'(in_sel);
`ifdef DEMUX_PKT_LOCK_EN
      if (m_lock) e = m_lsel;
`endif
      exp_rdy = (e >= 4) || (mq[e].size() == 0) || out_ready[e];
      chk("rnd_in_ready", in_ready, exp_rdy);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rnd_valid%0d", k), out_valid[k], mq[k].size() != 0);
        chk($sformatf("rnd_data%0d", k), out_data[k*8 +: 8], m_last[k]);
      end
      chk("rnd_drop", drop_count, m_drop);
      for (int k = 0; k < 4; k++)
        if (out_ready[k] && mq[k].size() != 0) void'(mq[k].pop_front());
      if (in_valid && exp_rdy) begin
        if (e < 4) begin
          mq[e].push_back(in_data);
          m_last[e] = in_data;
        end else if (m_drop < 255) begin
          m_drop++;
        end
`ifdef DEMUX_PKT_LOCK_EN
        if (!m_lock && !in_last) begin
          m_lock = 1'b1; m_lsel = int'(in_sel);
        end else if (m_lock && in_last) begin
          m_lock = 1'b0;
        end
`endif
      end
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Drop saturation on the 3-channel instance
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      c3_in_valid = 1'b1; c3_in_sel = 2'd3; c3_in_data = 8'(n);
      #1;
      chk("sat_in_ready", c3_in_ready, 1);
      chk("sat_out_valid", c3_out_valid, 0);
      if (n == 100) chk("sat_drop_100", c3_drop, 100);
    end
    @(posedge clk); #1;
    chk("sat_drop_final", c3_drop, 255);
    chk("sat_valid_final", c3_out_valid, 0);
    @(negedge clk);
    c3_in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
